alu_req_sched: RTL
==================

// Module: alu_req_sched
// PURPOSE
//  Shares one combinational 32-bit ALU among NUM_REQ requesters.
//  Round-robin arbitration picks one request at a time and drives the registered operands/ctrl into the ALU.
//  It waits ALU_LAT cycles, captures the result and Zero flag, then returns them to the winner on a valid/ready response.
//  Sits between requester ports (valid/ready) and the ALU's dataA_i/dataB_i/ALUCtrl_i inputs.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  DATA_W   32  operand/result width
//  CTRL_W   3   ALU control width
//  ALU_LAT  1   cycles from operand issue to sampling result (>=1)
// PORTS
//  clk_i         in   1                 single clock, all logic on posedge
//  rst_i         in   1                 synchronous, active-low reset
//  req_valid_i   in   NUM_REQ           per-requester request valid
//  req_ready_o   out  NUM_REQ           per-requester accept (one-hot or 0)
//  req_a_i       in   NUM_REQ*DATA_W    operand A, requester k at [k*DATA_W +: DATA_W]
//  req_b_i       in   NUM_REQ*DATA_W    operand B, same packing
//  req_ctrl_i    in   NUM_REQ*CTRL_W    ALU ctrl, same packing
//  rsp_valid_o   out  NUM_REQ           response valid to the winning requester
//  rsp_ready_i   in   NUM_REQ           response accept
//  rsp_result_o  out  DATA_W            shared response data (qualified by rsp_valid_o)
//  rsp_zero_o    out  1                 captured Zero flag
//  alu_a_o       out  DATA_W            to ALU dataA_i
//  alu_b_o       out  DATA_W            to ALU dataB_i
//  alu_ctrl_o    out  CTRL_W            to ALU ALUCtrl_i
//  alu_result_i  in   DATA_W            from ALU ALUResult_o
//  alu_zero_i    in   1                 from ALU Zero_o
//  busy_o        out  1                 high whenever state != IDLE
// BEHAVIOUR
//  - Reset (rst_i==0 at posedge): state=IDLE; alu_a/b/ctrl, rsp_result, rsp_zero = 0; rsp_valid_o=0; rr pointer=NUM_REQ-1, so req 0 has first priority.
//  - Reset mid-operation aborts the in-flight op; its response is never produced.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: winner g = first set req_valid_i scanning from (ptr+1) mod NUM_REQ upward with wrap.
//    - req_ready_o[g]=1 combinationally; all other ready bits are 0. Ready is 0 in every other state.
//    - Transfer on valid&ready: latch A/B/ctrl of g into alu_*_o, store g, ptr<=g, cnt<=ALU_LAT-1, go EXEC.
//  - EXEC: alu_*_o held stable. When cnt==0, register rsp_result<=alu_result_i and rsp_zero<=alu_zero_i, go RESP; else cnt--.
//  - RESP: rsp_valid_o[g]=1, held with data stable until rsp_ready_i[g]. On the handshake cycle go IDLE.
//    - rsp_ready_i of non-winners is ignored.
//  - Latency: accept at cycle T -> rsp_valid_o at T+1+ALU_LAT. Min spacing between accepts is ALU_LAT+2 cycles.
//  - alu_*_o keep their last values after the op completes; no toggling while idle.
//  - Requester rule: req_valid_i, once high, holds until accepted with operands stable. The scheduler does not depend on this for correctness.
//  - Simultaneous requests: exactly one accepted per IDLE cycle. Each continuously requesting port is served within NUM_REQ ops.
//  - A requester may raise req_valid_i for its next op while its own response is pending. It is considered only in IDLE, after the current response completes.
// STRUCTURE
//  - Package alu_sched_pkg:
//    - state_t enum {IDLE, EXEC, RESP};
//    - default DATA_W/CTRL_W localparams;
//    - function for the index width ($clog2(NUM_REQ)).
//  - Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs one-hot gnt and binary gnt_idx. Purely combinational.
//  - Top holds the FSM, latency counter, operand/response registers and the pointer register.
// TESTING (bench ALU stub: result=A+B, zero=(result==0); ALU_LAT=1 unless noted)
//  1. Reset with all valid low -> all outputs 0, busy_o=0. First op from req1, A=5 B=7 -> rsp_valid_o=4'b0010 two cycles after accept, result=12, zero=0.
//  2. All 4 valid from reset, rsp_ready_i tied high -> grant order 0,1,2,3,0. Accepts 3 cycles apart.
//  3. req2 A=32'hFFFFFFFF B=1 -> result=0, rsp_zero_o=1 (wrap-around).
//  4. Hold rsp_ready_i[0]=0 for 5 cycles -> rsp_valid_o[0] stays high with data stable, req_ready_o=0 throughout, no new accept.
//  5. Pull rst_i low during EXEC -> next cycle IDLE, rsp_valid_o=0, no response for the aborted op. After reset, req0 is granted first.
//  6. ALU_LAT=3 build: accept at T -> alu_*_o stable T+1..T+3, rsp_valid_o asserted at T+4.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and helpers for the ALU request scheduler.
package alu_sched_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_CTRL_W  = 3;
    localparam int unsigned DEF_ALU_LAT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index width for n entries, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_req_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first request strictly after i_ptr, wrapping.
module rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]           i_req,
    input  logic [idx_w(N)-1:0]    i_ptr,
    output logic [N-1:0]           o_gnt,
    output logic [idx_w(N)-1:0]    o_gnt_idx
);

    localparam int unsigned IW = idx_w(N);

    logic [IW:0] w_pos;
    logic        w_found;

    // Walk candidates ptr+1 .. ptr+N; sum stays below 2N so one wrap subtraction suffices.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_pos     = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            w_pos = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_pos >= (IW+1)'(N)) begin
                w_pos = w_pos - (IW+1)'(N);
            end
            if (!w_found && i_req[w_pos[IW-1:0]]) begin
                w_found   = 1'b1;
                o_gnt_idx = w_pos[IW-1:0];
            end
        end
        if (w_found) begin
            o_gnt = N'(1) << o_gnt_idx;
        end
    end

endmodule

// File: rtl/alu_req_sched.sv
// Shares one combinational ALU among NUM_REQ requesters with round-robin arbitration
// and a valid/ready response carrying the captured result and Zero flag.
module alu_req_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CTRL_W  = DEF_CTRL_W,
    parameter int unsigned ALU_LAT = DEF_ALU_LAT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b_i,
    input  logic [NUM_REQ*CTRL_W-1:0]   req_ctrl_i,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    input  logic [NUM_REQ-1:0]          rsp_ready_i,
    output logic [DATA_W-1:0]           rsp_result_o,
    output logic                        rsp_zero_o,
    output logic [DATA_W-1:0]           alu_a_o,
    output logic [DATA_W-1:0]           alu_b_o,
    output logic [CTRL_W-1:0]           alu_ctrl_o,
    input  logic [DATA_W-1:0]           alu_result_i,
    input  logic                        alu_zero_i,
    output logic                        busy_o
);

    localparam int unsigned IDX_W = idx_w(NUM_REQ);
    localparam int unsigned CNT_W = idx_w(ALU_LAT);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_gnt_idx;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]    r_alu_a;
    logic [DATA_W-1:0]    r_alu_b;
    logic [CTRL_W-1:0]    r_alu_ctrl;
    logic [DATA_W-1:0]    r_rsp_result;
    logic                 r_rsp_zero;
    logic                 r_busy;

    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic [IDX_W-1:0]     w_arb_idx;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_rsp_done;

    rr_arbiter #(
        .N         (NUM_REQ)
    ) u_arb (
        .i_req     (req_valid_i),
        .i_ptr     (r_ptr),
        .o_gnt     (w_arb_gnt),
        .o_gnt_idx (w_arb_idx)
    );

    // State register; busy mirrors the next state so it is high exactly when not IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    // Next state and handshake strobes; ready is only offered while IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_rsp_done  = 1'b0;
        req_ready_o = '0;
        case (r_state)
            IDLE: begin
                req_ready_o = w_arb_gnt;
                if (|(req_valid_i & w_arb_gnt)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i[r_gnt_idx]) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch, latency counter and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= '0;
            r_gnt_idx  <= '0;
            r_ptr      <= IDX_W'(NUM_REQ - 1);
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_alu_a    <= req_a_i[32'(w_arb_idx) * DATA_W +: DATA_W];
            r_alu_b    <= req_b_i[32'(w_arb_idx) * DATA_W +: DATA_W];
            r_alu_ctrl <= req_ctrl_i[32'(w_arb_idx) * CTRL_W +: CTRL_W];
            r_gnt_idx  <= w_arb_idx;
            r_ptr      <= w_arb_idx;
            r_cnt      <= CNT_W'(ALU_LAT - 1);
        end else if ((r_state == EXEC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Response registers stay stable from capture until the winner's handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_valid  <= '0;
        end else if (w_capture) begin
            r_rsp_result <= alu_result_i;
            r_rsp_zero   <= alu_zero_i;
            r_rsp_valid  <= NUM_REQ'(1) << r_gnt_idx;
        end else if (w_rsp_done) begin
            r_rsp_valid  <= '0;
        end
    end

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_result_o = r_rsp_result;
    assign rsp_zero_o   = r_rsp_zero;
    assign alu_a_o      = r_alu_a;
    assign alu_b_o      = r_alu_b;
    assign alu_ctrl_o   = r_alu_ctrl;
    assign busy_o       = r_busy;

endmodule
